board_engine: RTL and testbench

Sequential 4x4 2048 game-board engine that sits directly upstream of the VGA pixel generator and drives its sixteen tile-value buses and its `win` and `GG` flags. It accepts one-cycle direction pulses from the debounced input stage and slides and merges the board one line per cycle. It then spawns a new tile at a pseudo-random empty cell and re-evaluates the win and game-over conditions. A load port lets the bench and debug logic preset individual cells.

---
 rtl/board_engine_if.sv | 31 +++
 rtl/board_engine.sv | 200 ++++++++++++++++++++
 tb/tb_board_engine.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_engine_if.sv
// board_engine_if: control and tile-value bundle between the game-board
// engine and its neighbours (input stage, VGA pixel generator, bench).
//   master : drives new_game, move_*, load_*; observes tiles and flags
//   slave  : the engine itself
interface board_engine_if;
    logic        new_game;
    logic        move_up, move_down, move_left, move_right;
    logic        load_en;
    logic [3:0]  load_idx;
    logic [11:0] load_val;
    logic [11:0] number_0,  number_1,  number_2,  number_3;
    logic [11:0] number_4,  number_5,  number_6,  number_7;
    logic [11:0] number_8,  number_9,  number_10, number_11;
    logic [11:0] number_12, number_13, number_14, number_15;
    logic        win, GG, busy;

    modport master (
        output new_game, move_up, move_down, move_left, move_right,
               load_en, load_idx, load_val,
        input  number_0, number_1, number_2, number_3, number_4, number_5,
               number_6, number_7, number_8, number_9, number_10, number_11,
               number_12, number_13, number_14, number_15, win, GG, busy
    );
    modport slave (
        input  new_game, move_up, move_down, move_left, move_right,
               load_en, load_idx, load_val,
        output number_0, number_1, number_2, number_3, number_4, number_5,
               number_6, number_7, number_8, number_9, number_10, number_11,
               number_12, number_13, number_14, number_15, win, GG, busy
    );
endinterface

// File: rtl/board_engine.sv
// board_engine: sequential 4x4 2048 board. Slides/merges one line per cycle,
// spawns a 2/4 tile at a pseudo-random empty cell, then evaluates win/GG.
//   clk, rst : clock, async active-high reset
//   bus      : board_engine_if.slave (moves, new_game, cell load port,
//              16 registered tile values, win, GG, busy)
module board_engine #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    board_engine_if.slave bus
);
    typedef enum logic [2:0] {S_INIT, S_MOVE, S_SPAWN, S_CHECK, S_IDLE} state_t;
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

    state_t            state;
    dir_t              dir;
    logic [15:0][11:0] cells;
    logic [1:0]        line;
    logic              moved;
    logic [3:0]        scan, scan_cnt;
    logic [15:0]       lfsr, lfsr_next;
    logic              win_r, gg_r;

    // Cell index of position p (0 = front) in line l for a given direction.
    function automatic logic [3:0] cell_idx(input dir_t d, input logic [1:0] l,
                                            input logic [1:0] p);
        case (d)
            D_LEFT:  return {l, p};
            D_RIGHT: return {l, ~p};
            D_UP:    return {p, l};
            default: return {~p, l};
        endcase
    endfunction

    // Compact toward the front, then merge equal pairs front-first; a merged
    // tile is skipped so it cannot merge twice.
    function automatic logic [3:0][11:0] slide_line(input logic [3:0][11:0] in);
        logic [4:0][11:0] c;
        logic [3:0][11:0] out;
        logic [2:0]       j;
        logic             skip;
        c = '0;
        j = 3'd0;
        for (int p = 0; p < 4; p++)
            if (in[p] != 12'd0) begin
                c[j] = in[p];
                j    = j + 3'd1;
            end
        out  = '0;
        j    = 3'd0;
        skip = 1'b0;
        for (int p = 0; p < 4; p++) begin
            if (skip) skip = 1'b0;
            else begin
                // c[4] is always 0, so the last slot never merges
                if (c[p] != 12'd0 && c[p] == c[p+1]) begin
                    out[j[1:0]] = c[p] << 1;
                    skip        = 1'b1;
                end else
                    out[j[1:0]] = c[p];
                j = j + 3'd1;
            end
        end
        return out;
    endfunction

    logic [3:0][11:0] line_in, line_out;
    logic             line_chg;
    always_comb begin
        line_in = '0;
        for (int p = 0; p < 4; p++)
            line_in[p] = cells[cell_idx(dir, line, 2'(p))];
        line_out = slide_line(line_in);
        line_chg = (line_out != line_in);
    end

    logic win_c, gg_c, full, pair;
    always_comb begin
        win_c = 1'b0;
        full  = 1'b1;
        pair  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (cells[i] == 12'h800) win_c = 1'b1;
            if (cells[i] == 12'd0)   full  = 1'b0;
        end
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 3; b++) begin
                if (cells[4*a+b] == cells[4*a+b+1]) pair = 1'b1;  // horizontal
                if (cells[4*b+a] == cells[4*b+a+4]) pair = 1'b1;  // vertical
            end
        gg_c = full & ~pair;
    end

    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

    logic        spawn_empty;
    logic [11:0] spawn_val;
    logic        any_move;
    dir_t        req_dir;
    assign spawn_empty = (cells[scan] == 12'd0);
    assign spawn_val   = (lfsr[6:4] == 3'd0) ? 12'd4 : 12'd2;
    assign any_move    = bus.move_up | bus.move_down | bus.move_left | bus.move_right;
    assign req_dir     = bus.move_up   ? D_UP   :
                         bus.move_down ? D_DOWN :
                         bus.move_left ? D_LEFT : D_RIGHT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_INIT;
            dir      <= D_UP;
            cells    <= '0;
            line     <= 2'd0;
            moved    <= 1'b0;
            scan     <= LFSR_SEED[3:0];
            scan_cnt <= 4'd0;
            lfsr     <= LFSR_SEED;
            win_r    <= 1'b0;
            gg_r     <= 1'b0;
        end else begin
            lfsr <= lfsr_next;
            if (bus.new_game) begin
                cells    <= '0;
                win_r    <= 1'b0;
                gg_r     <= 1'b0;
                state    <= S_INIT;
                scan     <= lfsr[3:0];
                scan_cnt <= 4'd0;
            end else begin
                case (state)
                    // INIT performs the first spawn itself, SPAWN the second
                    S_INIT, S_SPAWN: begin
                        if (spawn_empty) cells[scan] <= spawn_val;
                        if (spawn_empty || scan_cnt == 4'd15) begin
                            if (state == S_INIT) begin
                                state    <= S_SPAWN;
                                scan     <= lfsr[3:0];
                                scan_cnt <= 4'd0;
                            end else
                                state <= S_CHECK;
                        end else begin
                            scan     <= scan + 4'd1;
                            scan_cnt <= scan_cnt + 4'd1;
                        end
                    end
                    S_MOVE: begin
                        for (int p = 0; p < 4; p++)
                            cells[cell_idx(dir, line, 2'(p))] <= line_out[p];
                        moved <= moved | line_chg;
                        line  <= line + 2'd1;
                        if (line == 2'd3) begin
                            if (moved | line_chg) begin
                                state    <= S_SPAWN;
                                scan     <= lfsr[3:0];
                                scan_cnt <= 4'd0;
                            end else
                                state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        win_r <= win_r | win_c;
                        gg_r  <= gg_r | gg_c;
                        state <= S_IDLE;
                    end
                    S_IDLE: begin
                        if (bus.load_en)
                            cells[bus.load_idx] <= bus.load_val;
                        else if (any_move && !win_r && !gg_r) begin
                            dir   <= req_dir;
                            line  <= 2'd0;
                            moved <= 1'b0;
                            state <= S_MOVE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.win  = win_r;
    assign bus.GG   = gg_r;
    assign bus.number_0  = cells[0];
    assign bus.number_1  = cells[1];
    assign bus.number_2  = cells[2];
    assign bus.number_3  = cells[3];
    assign bus.number_4  = cells[4];
    assign bus.number_5  = cells[5];
    assign bus.number_6  = cells[6];
    assign bus.number_7  = cells[7];
    assign bus.number_8  = cells[8];
    assign bus.number_9  = cells[9];
    assign bus.number_10 = cells[10];
    assign bus.number_11 = cells[11];
    assign bus.number_12 = cells[12];
    assign bus.number_13 = cells[13];
    assign bus.number_14 = cells[14];
    assign bus.number_15 = cells[15];
endmodule

// File: tb/tb_board_engine.sv
// tb_board_engine: scoreboard bench for board_engine. Stimulus pushes the
// expected outcome of each operation; a monitor checks it when busy falls.
module tb_board_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    board_engine_if bus();
    board_engine #(.LFSR_SEED(16'hACE1)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [15:0][11:0] act;
    assign act[0]  = bus.number_0;   assign act[1]  = bus.number_1;
    assign act[2]  = bus.number_2;   assign act[3]  = bus.number_3;
    assign act[4]  = bus.number_4;   assign act[5]  = bus.number_5;
    assign act[6]  = bus.number_6;   assign act[7]  = bus.number_7;
    assign act[8]  = bus.number_8;   assign act[9]  = bus.number_9;
    assign act[10] = bus.number_10;  assign act[11] = bus.number_11;
    assign act[12] = bus.number_12;  assign act[13] = bus.number_13;
    assign act[14] = bus.number_14;  assign act[15] = bus.number_15;

    // kind: 0 = init (two fresh tiles), 1 = move that changes board, 2 = no-op move
    typedef struct { int kind; logic [15:0][11:0] exp; } exp_t;
    exp_t sb[$];

    logic [15:0][11:0] model;
    bit   m_win = 0, m_gg = 0;
    int   errors = 0, checks = 0;

    task automatic chk(input string nm, input bit ok, input longint a, input longint e);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    function automatic int ndiff(input logic [15:0][11:0] a, input logic [15:0][11:0] b);
        int n = 0;
        for (int i = 0; i < 16; i++) if (a[i] != b[i]) n++;
        return n;
    endfunction

    function automatic bit rule_win(input logic [15:0][11:0] b);
        for (int i = 0; i < 16; i++) if (b[i] == 12'd2048) return 1;
        return 0;
    endfunction

    function automatic bit rule_gg(input logic [15:0][11:0] b);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (b[r*4+c] == 0) return 0;
                if (c < 3 && b[r*4+c] == b[r*4+c+1]) return 0;
                if (r < 3 && b[r*4+c] == b[(r+1)*4+c]) return 0;
            end
        return 1;
    endfunction

    // Reference slide: d 0=up 1=down 2=left 3=right
    function automatic logic [15:0][11:0] slide_board(input logic [15:0][11:0] b, input int d);
        logic [15:0][11:0] o;
        int idx[4];
        int q[$];
        int r[$];
        int a;
        o = b;
        for (int l = 0; l < 4; l++) begin
            for (int p = 0; p < 4; p++)
                case (d)
                    0:       idx[p] = p*4 + l;
                    1:       idx[p] = (3-p)*4 + l;
                    2:       idx[p] = l*4 + p;
                    default: idx[p] = l*4 + 3 - p;
                endcase
            q.delete();
            r.delete();
            for (int p = 0; p < 4; p++) if (b[idx[p]] != 0) q.push_back(int'(b[idx[p]]));
            while (q.size() > 0) begin
                a = q.pop_front();
                if (q.size() > 0 && q[0] == a) begin
                    void'(q.pop_front());
                    r.push_back(2*a);
                end else
                    r.push_back(a);
            end
            while (r.size() < 4) r.push_back(0);
            for (int p = 0; p < 4; p++) o[idx[p]] = 12'(r[p]);
        end
        return o;
    endfunction

    // Monitor: each falling edge of busy completes one queued operation.
    int busy_cnt = 0;
    bit prev_busy = 1;
    always @(negedge clk) begin
        exp_t e;
        int   nz, newc;
        bit   bad;
        if (rst) begin
            busy_cnt  = 0;
            prev_busy = 1;
        end else begin
            if (bus.busy) busy_cnt++;
            else if (prev_busy) begin
                if (sb.size() == 0) chk("unexpected_done", 0, busy_cnt, 0);
                else begin
                    e = sb[0];
                    nz = 0; newc = 0; bad = 0;
                    case (e.kind)
                        0: begin
                            for (int i = 0; i < 16; i++)
                                if (act[i] != 0) begin
                                    nz++;
                                    if (act[i] != 2 && act[i] != 4) bad = 1;
                                end
                            chk("init_tiles", nz == 2 && !bad, nz, 2);
                            chk("init_busy", busy_cnt >= 2 && busy_cnt <= 33, busy_cnt, 2);
                            model = act; m_win = 0; m_gg = 0;
                        end
                        1: begin
                            for (int i = 0; i < 16; i++)
                                if (act[i] != e.exp[i]) begin
                                    if (e.exp[i] == 0 && (act[i] == 2 || act[i] == 4)) newc++;
                                    else bad = 1;
                                end
                            chk("move_board", !bad && newc == 1, bad ? -1 : newc, 1);
                            chk("move_busy", busy_cnt >= 6 && busy_cnt <= 21, busy_cnt, 6);
                            model = act;
                        end
                        default: begin
                            chk("still_board", act == e.exp, ndiff(act, e.exp), 0);
                            chk("still_busy", busy_cnt == 5, busy_cnt, 5);
                            model = e.exp;
                        end
                    endcase
                    m_win = m_win | rule_win(model);
                    m_gg  = m_gg  | rule_gg(model);
                    chk("win", bus.win == m_win, bus.win, m_win);
                    chk("gg",  bus.GG  == m_gg,  bus.GG,  m_gg);
                    void'(sb.pop_front());
                end
                busy_cnt = 0;
            end
            prev_busy = bus.busy;
        end
    end

    task automatic wait_done();
        for (int c = 0; c < 300 && sb.size() != 0; c++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("timeout", 0, sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic pulse(input logic [3:0] udlr);
        @(negedge clk);
        {bus.move_up, bus.move_down, bus.move_left, bus.move_right} = udlr;
        @(negedge clk);
        {bus.move_up, bus.move_down, bus.move_left, bus.move_right} = 4'b0;
    endtask

    task automatic idle_check(input string nm, input int n);
        int hi = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (bus.busy) hi++;
        end
        chk({nm, "_busy"}, hi == 0, hi, 0);
        chk({nm, "_board"}, act == model, ndiff(act, model), 0);
    endtask

    task automatic load_board(input logic [15:0][11:0] b);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.load_en  = 1'b1;
            bus.load_idx = 4'(i);
            bus.load_val = b[i];
        end
        @(negedge clk);
        bus.load_en = 1'b0;
        model = b;
        chk("load", act == model, ndiff(act, model), 0);
    endtask

    task automatic do_move(input logic [3:0] udlr);
        exp_t e;
        int   d;
        d = udlr[3] ? 0 : udlr[2] ? 1 : udlr[1] ? 2 : 3;
        if (m_win || m_gg) begin
            pulse(udlr);
            idle_check("frozen", 6);
        end else begin
            e.exp  = slide_board(model, d);
            e.kind = (e.exp != model) ? 1 : 2;
            sb.push_back(e);
            pulse(udlr);
            wait_done();
        end
    endtask

    task automatic new_game_req();
        exp_t e;
        e.kind = 0;
        e.exp  = '0;
        sb.push_back(e);
        @(negedge clk);
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        chk("ng_clear", act == '0, ndiff(act, '0), 0);
        chk("ng_flags", !bus.win && !bus.GG, {bus.win, bus.GG}, 0);
        wait_done();
    endtask

    initial begin
        logic [15:0][11:0] b;
        exp_t e;
        bus.new_game = 0;
        {bus.move_up, bus.move_down, bus.move_left, bus.move_right} = 4'b0;
        bus.load_en = 0; bus.load_idx = 0; bus.load_val = 0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy == 1'b1, bus.busy, 1);
        chk("rst_board", act == '0, ndiff(act, '0), 0);
        chk("rst_flags", !bus.win && !bus.GG, {bus.win, bus.GG}, 0);
        e.kind = 0; e.exp = '0;
        sb.push_back(e);
        #2 rst = 1'b0;
        wait_done();

        // row 0 = 2,2,2,2 slid left
        b = '0; for (int i = 0; i < 4; i++) b[i] = 12'd2;
        load_board(b);
        do_move(4'b0010);

        // column 0 = 4,0,0,4 slid up
        b = '0; b[0] = 12'd4; b[12] = 12'd4;
        load_board(b);
        do_move(4'b1000);

        // 1024+1024 -> win, then frozen
        b = '0; b[0] = 12'd1024; b[1] = 12'd1024;
        load_board(b);
        do_move(4'b0010);
        chk("win_set", bus.win == 1'b1, bus.win, 1);
        do_move(4'b0001);
        new_game_req();

        // checkerboard -> no change, GG
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) b[r*4+c] = ((r + c) % 2) ? 12'd4 : 12'd2;
        load_board(b);
        do_move(4'b0100);
        chk("gg_set", bus.GG == 1'b1, bus.GG, 1);
        new_game_req();

        // up beats left; down during MOVE is dropped
        b = '0; b[0] = 12'd2; b[1] = 12'd2;
        load_board(b);
        e.kind = 2; e.exp = b;
        sb.push_back(e);
        pulse(4'b1010);
        pulse(4'b0100);
        wait_done();
        idle_check("no_queue", 8);

        // asynchronous reset in the middle of a move
        b = '0; b[4] = 12'd8; b[5] = 12'd8;
        load_board(b);
        pulse(4'b0010);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_board", act == '0, ndiff(act, '0), 0);
        chk("midrst_state", bus.busy && !bus.win && !bus.GG, {bus.busy, bus.win, bus.GG}, 4);
        sb.delete();
        e.kind = 0; e.exp = '0;
        sb.push_back(e);
        @(negedge clk);
        #2 rst = 1'b0;
        wait_done();

        // randomized mix of moves, board loads and restarts
        for (int it = 0; it < 80; it++) begin
            int sel;
            logic [3:0] udlr;
            sel = $urandom_range(0, 11);
            if (sel == 0) new_game_req();
            else if (sel <= 2) begin
                for (int i = 0; i < 16; i++)
                    case ($urandom_range(0, 7))
                        4:       b[i] = 12'd2;
                        5:       b[i] = 12'd4;
                        6:       b[i] = 12'd8;
                        7:       b[i] = 12'd16;
                        default: b[i] = 12'd0;
                    endcase
                load_board(b);
            end else begin
                udlr = 4'(1 << $urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) udlr = udlr | 4'(1 << $urandom_range(0, 3));
                do_move(udlr);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
